// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types, constants and the round-robin search helper for uart_tx_arbiter.
// The optional source-tag header is enabled with UART_TX_ARB_SOURCE_TAG_EN.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TAG  = 2'd1,
    SEND = 2'd2
  } arb_state_t;

  localparam logic [3:0] TAG_NIBBLE = 4'hA;

  typedef struct packed {
    arb_state_t state;
    logic [3:0] rr_ptr;
    logic [7:0] burst_cnt;
  } arb_dbg_t;

  // Returns {found, index}: the first set bit of valid at or above ptr, wrapping at n.
  function automatic logic [4:0] rr_pick(input logic [15:0] valid, input logic [3:0] ptr,
                                         input int n);
    logic [4:0] res;
    int         j;
    res = '0;
    for (int k = 0; k < 16; k++) begin
      j = (int'(ptr) + k) % n;
      if (k < n && !res[4] && valid[j[3:0]]) res = {1'b1, j[3:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/uart_tx_rr_picker.sv
// Combinational round-robin selector: first valid requester at or above rr_ptr, with wrap.
// Part of uart_tx_arbiter (optional tag feature: UART_TX_ARB_SOURCE_TAG_EN, not used here).
module uart_tx_rr_picker
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = 4,
  parameter int GW             = $clog2(NUM_REQUESTERS)
) (
  input  logic [NUM_REQUESTERS-1:0] req_valid,
  input  logic [GW-1:0]             rr_ptr,
  output logic                      found,
  output logic [GW-1:0]             pick_id
);

  logic [4:0] pick;

  always_comb begin
    pick    = rr_pick(16'(req_valid), 4'(rr_ptr), NUM_REQUESTERS);
    found   = pick[4];
    pick_id = GW'(pick[3:0]);
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter write port among byte-stream clients.
// Define UART_TX_ARB_SOURCE_TAG_EN to prefix every grant with a {4'hA, id} header byte.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = 4,
  parameter int MAX_BURST      = 16
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_REQUESTERS-1:0]         req_valid,
  input  logic [7:0]                        req_data [NUM_REQUESTERS],
  input  logic [NUM_REQUESTERS-1:0]         req_last,
  output logic [NUM_REQUESTERS-1:0]         req_ready,
  output logic [7:0]                        tx_data,
  output logic                              tx_write_enable,
  input  logic                              tx_buffer_full,
  output logic [$clog2(NUM_REQUESTERS)-1:0] grant_id,
  output logic                              busy,
  output arb_dbg_t                          dbg
);

  localparam int GW = $clog2(NUM_REQUESTERS);

  arb_state_t    state_q, state_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_we_q, tx_we_d;
  logic          busy_q, busy_d;

  logic          pick_found;
  logic [GW-1:0] pick_id;
  logic          hs;
  logic [GW-1:0] next_ptr;

  uart_tx_rr_picker #(
    .NUM_REQUESTERS(NUM_REQUESTERS),
    .GW            (GW)
  ) u_picker (
    .req_valid(req_valid),
    .rr_ptr   (rr_ptr_q),
    .found    (pick_found),
    .pick_id  (pick_id)
  );

  // A byte moves on cycles where req_valid[i] && req_ready[i]; only the granted
  // client ever sees ready, and ready follows buffer_full combinationally.
  always_comb begin
    req_ready = '0;
    if (state_q == SEND && !tx_buffer_full) req_ready[grant_q] = 1'b1;
    hs       = (state_q == SEND) && !tx_buffer_full && req_valid[grant_q];
    next_ptr = (grant_q == GW'(NUM_REQUESTERS - 1)) ? '0 : grant_q + 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    tx_we_d   = 1'b0;
    busy_d    = busy_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_id;
          busy_d  = 1'b1;
          cnt_d   = '0;
`ifdef UART_TX_ARB_SOURCE_TAG_EN
          state_d = TAG;
`else
          state_d = SEND;
`endif
        end
      end
`ifdef UART_TX_ARB_SOURCE_TAG_EN
      TAG: begin
        if (!tx_buffer_full) begin
          tx_data_d = {TAG_NIBBLE, 4'(grant_q)};
          tx_we_d   = 1'b1;
          state_d   = SEND;
        end
      end
`endif
      SEND: begin
        if (hs) begin
          tx_data_d = req_data[grant_q];
          tx_we_d   = 1'b1;
          cnt_d     = cnt_q + 8'd1;
          // last and burst limit on the same byte still rotate only once
          if (req_last[grant_q] || (cnt_q + 8'd1 == 8'(MAX_BURST))) begin
            rr_ptr_d = next_ptr;
            busy_d   = 1'b0;
            state_d  = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      cnt_q     <= '0;
      tx_data_q <= '0;
      tx_we_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
      tx_data_q <= tx_data_d;
      tx_we_q   <= tx_we_d;
      busy_q    <= busy_d;
    end
  end

  assign tx_data         = tx_data_q;
  assign tx_write_enable = tx_we_q;
  assign grant_id        = grant_q;
  assign busy            = busy_q;
  assign dbg             = '{state: state_q, rr_ptr: 4'(rr_ptr_q), burst_cnt: cnt_q};

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (4 clients, MAX_BURST 4); also valid with
// UART_TX_ARB_SOURCE_TAG_EN, where each grant expects a header byte first.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  import uart_tx_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int MB = 4;
`ifdef UART_TX_ARB_SOURCE_TAG_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic         clock;
  logic         reset;
  logic [N-1:0] req_valid;
  logic [7:0]   req_data [N];
  logic [N-1:0] req_last;
  logic [N-1:0] req_ready;
  logic [7:0]   tx_data;
  logic         tx_write_enable;
  logic         tx_buffer_full;
  logic [1:0]   grant_id;
  logic         busy;
  arb_dbg_t     dbg;

  int           n_vec;
  int           n_err;
  int           cyc;
  logic [8:0]   cq [N][$];
  logic [7:0]   exp_q[$];
  logic [1:0]   exp_g_q[$];
  int           wr_cyc[$];
  logic [N-1:0] hs;
  logic [8:0]   head;

  uart_tx_arbiter #(
    .NUM_REQUESTERS(N),
    .MAX_BURST     (MB)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_last       (req_last),
    .req_ready      (req_ready),
    .tx_data        (tx_data),
    .tx_write_enable(tx_write_enable),
    .tx_buffer_full (tx_buffer_full),
    .grant_id       (grant_id),
    .busy           (busy),
    .dbg            (dbg)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clock);
      cyc++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // driver: each client presents the head of its queue, pops on handshake
  initial begin
    req_valid = '0;
    req_last  = '0;
    for (int i = 0; i < N; i++) req_data[i] = 8'h00;
    forever begin
      @(negedge clock);
      for (int i = 0; i < N; i++) begin
        if (cq[i].size() > 0) begin
          head         = cq[i][0];
          req_valid[i] = 1'b1;
          req_data[i]  = head[7:0];
          req_last[i]  = head[8];
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
      #4;
      hs = req_valid & req_ready;
      @(posedge clock);
      for (int i = 0; i < N; i++)
        if (hs[i] && cq[i].size() > 0) void'(cq[i].pop_front());
    end
  end

  // scoreboard: every transmitter write must match the next expected byte and grant
  initial begin
    forever begin
      @(negedge clock);
      if (tx_write_enable === 1'b1) begin
        wr_cyc.push_back(cyc);
        if (exp_q.size() == 0) check("spurious_write", 32'(tx_data), 32'h100);
        else begin
          check("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
          check("tx_grant", 32'(grant_id), 32'(exp_g_q.pop_front()));
        end
      end
    end
  end

  task automatic drive_byte(input int c, input logic [7:0] d, input logic last);
    cq[c].push_back({last, d});
  endtask

  task automatic expect_byte(input logic [1:0] g, input logic [7:0] d);
    exp_q.push_back(d);
    exp_g_q.push_back(g);
  endtask

  task automatic expect_hdr(input logic [1:0] g);
    if (HDR == 1) expect_byte(g, {4'hA, 2'b00, g});
  endtask

  function automatic bit clients_idle();
    bit r;
    r = 1'b1;
    for (int i = 0; i < N; i++) if (cq[i].size() != 0) r = 1'b0;
    return r;
  endfunction

  task automatic wait_drain(input string tag);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clock);
      if (exp_q.size() == 0 && busy === 1'b0 && clients_idle()) done = 1'b1;
    end
    check(tag, 32'(done), 32'd1);
    @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < N; i++) cq[i].delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int  nwr;
    bit  done;
    n_vec          = 0;
    n_err          = 0;
    reset          = 1'b1;
    tx_buffer_full = 1'b0;

    // reset state
    repeat (3) @(negedge clock);
    check("rst_we", 32'(tx_write_enable), 32'd0);
    check("rst_data", 32'(tx_data), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rr", 32'(dbg.rr_ptr), 32'd0);
    check("rst_state", 32'(dbg.state), 32'(IDLE));
    reset = 1'b0;

    // single message, arbitration latency, back-to-back writes
    @(posedge clock); #1;
    wr_cyc.delete();
    drive_byte(0, 8'h11, 1'b0);
    drive_byte(0, 8'h22, 1'b0);
    drive_byte(0, 8'h33, 1'b1);
    expect_hdr(0);
    expect_byte(0, 8'h11);
    expect_byte(0, 8'h22);
    expect_byte(0, 8'h33);
    @(negedge clock);
    @(posedge clock);
    @(negedge clock);
    check("arb_busy", 32'(busy), 32'd1);
    check("arb_ready", 32'(req_ready), (HDR == 1) ? 32'd0 : 32'd1);
    wait_drain("single_drain");
    check("single_nwr", 32'(wr_cyc.size()), 32'(3 + HDR));
    if (wr_cyc.size() == 3 + HDR)
      check("single_consec", 32'(wr_cyc[wr_cyc.size() - 1] - wr_cyc[0]), 32'(2 + HDR));
    check("single_rr", 32'(dbg.rr_ptr), 32'd1);
    check("single_busy", 32'(busy), 32'd0);

    // round-robin fairness from pointer 0: grants 0,1,2,3,0
    do_reset();
    @(posedge clock); #1;
    drive_byte(0, 8'hA0, 1'b1);
    drive_byte(1, 8'hA1, 1'b1);
    drive_byte(2, 8'hA2, 1'b1);
    drive_byte(3, 8'hA3, 1'b1);
    drive_byte(0, 8'hA4, 1'b1);
    for (int i = 0; i < 5; i++) begin
      expect_hdr(2'(i % 4));
      expect_byte(2'(i % 4), 8'(8'hA0 + i));
    end
    wait_drain("rr_drain");
    check("rr_ptr_after", 32'(dbg.rr_ptr), 32'd1);

    // burst limit: client 1 rotates out after 4 bytes, client 2 interleaves
    @(posedge clock); #1;
    for (int i = 0; i < 6; i++) drive_byte(1, 8'(8'hB0 + i), (i == 5));
    drive_byte(2, 8'hC0, 1'b0);
    drive_byte(2, 8'hC1, 1'b1);
    expect_hdr(1);
    for (int i = 0; i < 4; i++) expect_byte(1, 8'(8'hB0 + i));
    expect_hdr(2);
    expect_byte(2, 8'hC0);
    expect_byte(2, 8'hC1);
    expect_hdr(1);
    expect_byte(1, 8'hB4);
    expect_byte(1, 8'hB5);
    wait_drain("burst_drain");
    check("burst_rr", 32'(dbg.rr_ptr), 32'd2);

    // backpressure on client 1; last coincides with the burst limit on D3
    do_reset();
    @(posedge clock); #1;
    for (int i = 0; i < 4; i++) drive_byte(1, 8'(8'hD0 + i), (i == 3));
    expect_hdr(1);
    for (int i = 0; i < 4; i++) expect_byte(1, 8'(8'hD0 + i));
    done = 1'b0;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clock);
      if (tx_write_enable === 1'b1) done = 1'b1;
    end
    check("bp_start", 32'(done), 32'd1);
    tx_buffer_full = 1'b1;
    nwr = 0;
    repeat (5) begin
      @(negedge clock);
      check("bp_ready", 32'(req_ready), 32'd0);
      if (tx_write_enable === 1'b1) nwr++;
    end
    check("bp_writes", 32'(nwr), 32'd0);
    tx_buffer_full = 1'b0;
    wait_drain("bp_drain");
    check("bp_rr_single_rotate", 32'(dbg.rr_ptr), 32'd2);

    // reset after the second byte of a five-byte message
    @(posedge clock); #1;
    for (int i = 0; i < 5; i++) drive_byte(2, 8'(8'hE0 + i), (i == 4));
    expect_hdr(2);
    expect_byte(2, 8'hE0);
    expect_byte(2, 8'hE1);
    done = 1'b0;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clock);
      if (exp_q.size() == 0) done = 1'b1;
    end
    check("mid_reach", 32'(done), 32'd1);
    reset = 1'b1;
    for (int i = 0; i < N; i++) cq[i].delete();
    @(negedge clock);
    check("mid_we", 32'(tx_write_enable), 32'd0);
    check("mid_data", 32'(tx_data), 32'd0);
    check("mid_ready", 32'(req_ready), 32'd0);
    check("mid_grant", 32'(grant_id), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_rr", 32'(dbg.rr_ptr), 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;
    drive_byte(3, 8'hF3, 1'b1);
    drive_byte(0, 8'hF0, 1'b1);
    expect_hdr(0);
    expect_byte(0, 8'hF0);
    expect_hdr(3);
    expect_byte(3, 8'hF3);
    wait_drain("post_reset_drain");

    // client 3 single byte (header then 0x55 back to back when tagging)
    @(posedge clock); #1;
    wr_cyc.delete();
    drive_byte(3, 8'h55, 1'b1);
    expect_hdr(3);
    expect_byte(3, 8'h55);
    wait_drain("tag_drain");
    check("tag_nwr", 32'(wr_cyc.size()), 32'(1 + HDR));
    if (wr_cyc.size() == 1 + HDR)
      check("tag_consec", 32'(wr_cyc[wr_cyc.size() - 1] - wr_cyc[0]), 32'(HDR));

    // lone client is re-granted after its release
    @(posedge clock); #1;
    drive_byte(1, 8'h66, 1'b1);
    drive_byte(1, 8'h77, 1'b1);
    expect_hdr(1);
    expect_byte(1, 8'h66);
    expect_hdr(1);
    expect_byte(1, 8'h77);
    wait_drain("regrant_drain");
    check("regrant_rr", 32'(dbg.rr_ptr), 32'd2);

    check("exp_left", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
